// File: rtl/rr_arb_pkg.sv
// Shared helpers for the round-robin arbiter family: channel-index width
// and the pointer value loaded at reset.
package rr_arb_pkg;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int unsigned sel_w_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Reset pointer sits on the last channel so channel 0 is searched first.
    function automatic int unsigned rst_ptr_of(input int unsigned n);
        return (n == 0) ? 0 : n - 1;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin pick: searches ptr+1, ptr+2, ... modulo N and
// grants the first requester. Holds no state, so other arbiters can reuse it.
module rr_arb_pick
    import rr_arb_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned SEL_W = sel_w_of(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // First requester after ptr wins; ptr itself is checked last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = SEL_W'((32'(ptr) + off) % N);
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input round-robin arbitrated mux with a one-entry registered output.
// Optional burst lock enabled by defining RR_ARB_MUX_LOCK_EN: a grant with
// in_last=0 pins the arbiter to that channel until its in_last beat.
module rr_arb_mux
    import rr_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N*WIDTH-1:0]       in_data,
    input  logic [N-1:0]             in_valid,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [N-1:0]             in_last,
`endif
    output logic [N-1:0]             in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [sel_w_of(N)-1:0]   out_sel
`ifdef RR_ARB_MUX_LOCK_EN
    ,
    output logic                     out_last
`endif
);

    localparam int unsigned      SEL_W   = sel_w_of(N);
    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(rst_ptr_of(N));

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;

    logic             load;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic             any;
    logic [WIDTH-1:0] win_data;

`ifdef RR_ARB_MUX_LOCK_EN
    logic             lock_q, lock_d;
    logic             out_last_q, out_last_d;
    logic             win_last;
`endif

    // Request vector seen by the picker; while locked only the owner counts.
    always_comb begin
        req = in_valid;
`ifdef RR_ARB_MUX_LOCK_EN
        if (lock_q) begin
            req          = '0;
            req[ptr_q]   = in_valid[ptr_q];
        end
`endif
    end

    rr_arb_pick #(
        .N(N)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // Winner's payload selected from the one-hot grant.
    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) win_data = in_data[i*WIDTH +: WIDTH];
        end
`ifdef RR_ARB_MUX_LOCK_EN
        win_last = |(in_last & gnt);
`endif
    end

    // Handshake and next-state: capture the winner whenever the stage can load.
    always_comb begin
        load        = !out_valid_q || out_ready;
        in_ready    = (load && !rst) ? gnt : '0;
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
`ifdef RR_ARB_MUX_LOCK_EN
        lock_d      = lock_q;
        out_last_d  = out_last_q;
`endif
        if (load) begin
            if (any) begin
                out_data_d  = win_data;
                out_sel_d   = gnt_idx;
                out_valid_d = 1'b1;
                ptr_d       = gnt_idx;
`ifdef RR_ARB_MUX_LOCK_EN
                lock_d      = !win_last;
                out_last_d  = win_last;
`endif
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= PTR_RST;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef RR_ARB_MUX_LOCK_EN
            lock_q      <= 1'b0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
`ifdef RR_ARB_MUX_LOCK_EN
            lock_q      <= lock_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
`ifdef RR_ARB_MUX_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: a 4x32 instance checked by a reference model and
// scoreboard plus directed checks, and a 3x8 instance for odd channel counts.
module tb_rr_arb_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-channel, 32-bit instance
    logic [31:0]  words [4];
    logic [127:0] in_data;
    logic [3:0]   in_valid = '0;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [1:0]   out_sel;
    logic [3:0]   in_last = 4'b1111;
    logic         out_last;

    // 3-channel, 8-bit instance
    logic [7:0]   w3 [3];
    logic [23:0]  in3_data;
    logic [2:0]   in3_valid = '0;
    logic [2:0]   in3_ready;
    logic [7:0]   out3_data;
    logic         out3_valid;
    logic         out3_ready = 1'b0;
    logic [1:0]   out3_sel;
    logic [2:0]   in3_last = 3'b111;
    logic         out3_last;

    int vectors = 0;
    int miscompares = 0;

    always_comb begin
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = words[i];
        for (int i = 0; i < 3; i++) in3_data[i*8 +: 8] = w3[i];
    end

    rr_arb_mux #(.WIDTH(32), .N(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef RR_ARB_MUX_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
`ifdef RR_ARB_MUX_LOCK_EN
        ,
        .out_last  (out_last)
`endif
    );

    rr_arb_mux #(.WIDTH(8), .N(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in3_data),
        .in_valid  (in3_valid),
`ifdef RR_ARB_MUX_LOCK_EN
        .in_last   (in3_last),
`endif
        .in_ready  (in3_ready),
        .out_data  (out3_data),
        .out_valid (out3_valid),
        .out_ready (out3_ready),
        .out_sel   (out3_sel)
`ifdef RR_ARB_MUX_LOCK_EN
        ,
        .out_last  (out3_last)
`endif
    );

    // ---------------- reference model + scoreboard (4-channel instance)
    typedef struct {
        logic [31:0] data;
        logic [1:0]  sel;
        logic        last;
    } exp_t;

    exp_t exp_q [$];
    int   m_ptr   = 3;
    logic m_valid = 1'b0;
    logic m_lock  = 1'b0;

    function automatic int pick4(input logic [3:0] v, input int p);
        int idx;
        for (int off = 1; off <= 4; off++) begin
            idx = (p + off) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_req(input logic [3:0] v, input logic lk, input int p);
        if (lk) return v & 4'(1 << p);
        return v;
    endfunction

    int   mdl_w;
    exp_t mdl_e;
    always @(posedge clk) begin
        if (rst) begin
            m_ptr   = 3;
            m_valid = 1'b0;
            m_lock  = 1'b0;
            exp_q.delete();
        end else if (!m_valid || out_ready) begin
            mdl_w = pick4(model_req(in_valid, m_lock, m_ptr), m_ptr);
            if (mdl_w >= 0) begin
                mdl_e.data = words[mdl_w];
                mdl_e.sel  = 2'(mdl_w);
`ifdef RR_ARB_MUX_LOCK_EN
                mdl_e.last = in_last[mdl_w];
                m_lock     = !in_last[mdl_w];
`else
                mdl_e.last = 1'b0;
`endif
                exp_q.push_back(mdl_e);
                m_ptr   = mdl_w;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    int         mon_w;
    logic [3:0] mon_rdy;
    exp_t       mon_e;
    always @(negedge clk) begin
        mon_w   = pick4(model_req(in_valid, m_lock, m_ptr), m_ptr);
        mon_rdy = (!rst && (!m_valid || out_ready) && mon_w >= 0) ? 4'(1 << mon_w) : 4'b0;
        vectors++;
        if (in_ready !== mon_rdy) begin
            miscompares++;
            $display("FAIL sb_in_ready: got %b expected %b at %0t", in_ready, mon_rdy, $time);
        end
        vectors++;
        if (out_valid !== m_valid) begin
            miscompares++;
            $display("FAIL sb_out_valid: got %b expected %b at %0t", out_valid, m_valid, $time);
        end
        if (m_valid && out_ready && !rst) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_underflow: got delivery sel %0d expected none at %0t", out_sel, $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e.data || out_sel !== mon_e.sel) begin
                    miscompares++;
                    $display("FAIL sb_word: got %h/%0d expected %h/%0d at %0t",
                             out_data, out_sel, mon_e.data, mon_e.sel, $time);
                end
`ifdef RR_ARB_MUX_LOCK_EN
                vectors++;
                if (out_last !== mon_e.last) begin
                    miscompares++;
                    $display("FAIL sb_last: got %b expected %b at %0t", out_last, mon_e.last, $time);
                end
`endif
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic to_drive();
        @(posedge clk);
        #2;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        to_drive();
        to_drive();
        to_sample();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (out_data !== 32'h0) begin miscompares++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
        vectors++;
        if (out_sel !== 2'd0) begin miscompares++; $display("FAIL rst_out_sel: got %0d expected 0", out_sel); end
        vectors++;
        if (in_ready !== 4'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b expected 0000", in_ready); end
        vectors++;
        if (out3_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out3_valid: got %b expected 0", out3_valid); end
        to_drive();
        rst      = 1'b0;
        in_valid = 4'b0;
    endtask

    task automatic test_round_robin();
        int seq [5] = '{0, 1, 2, 3, 0};
        words = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        to_drive();
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            to_sample();
            vectors++;
            if (in_ready !== 4'(1 << seq[k])) begin
                miscompares++;
                $display("FAIL rr_in_ready[%0d]: got %b expected %b", k, in_ready, 4'(1 << seq[k]));
            end
            if (k > 0) begin
                vectors++;
                if (out_sel !== 2'(seq[k-1]) || out_data !== words[seq[k-1]]) begin
                    miscompares++;
                    $display("FAIL rr_out[%0d]: got %0d/%h expected %0d/%h", k, out_sel, out_data,
                             seq[k-1], words[seq[k-1]]);
                end
            end
            to_drive();
        end
        in_valid = 4'b0;
        to_sample();
        vectors++;
        if (out_sel !== 2'd0 || out_data !== 32'hA0) begin
            miscompares++;
            $display("FAIL rr_wrap: got %0d/%h expected 0/000000a0", out_sel, out_data);
        end
        to_drive();
    endtask

    task automatic test_single();
        words[2] = 32'h55;
        in_valid = 4'b0100;
        to_sample();
        vectors++;
        if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL single_in_ready: got %b expected 0100", in_ready); end
        to_drive();
        in_valid = 4'b0;
        to_sample();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h55 || out_sel !== 2'd2) begin
            miscompares++;
            $display("FAIL single_out: got %b/%h/%0d expected 1/00000055/2", out_valid, out_data, out_sel);
        end
        to_drive();
    endtask

    task automatic test_stall();
        words     = '{32'hA0, 32'h11, 32'hA2, 32'hA3};
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        to_sample();
        vectors++;
        if (in_ready !== 4'b0010) begin miscompares++; $display("FAIL stall_capture: got %b expected 0010", in_ready); end
        to_drive();
        in_valid  = 4'hF;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            to_sample();
            vectors++;
            if (out_data !== 32'h11 || out_sel !== 2'd1) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got %h/%0d expected 00000011/1", k, out_data, out_sel);
            end
            vectors++;
            if (in_ready !== 4'b0) begin
                miscompares++;
                $display("FAIL stall_ready[%0d]: got %b expected 0000", k, in_ready);
            end
            to_drive();
        end
        out_ready = 1'b1;
        to_sample();
        vectors++;
        if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL stall_release: got %b expected 0100", in_ready); end
        to_drive();
        out_ready = 1'b0;
        to_sample();
        vectors++;
        if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 32'hA2) begin
            miscompares++;
            $display("FAIL stall_no_bubble: got %b/%0d/%h expected 1/2/000000a2", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_reset_mid_stall();
        to_drive();
        rst = 1'b1;
        to_sample();
        vectors++;
        if (in_ready !== 4'b0) begin miscompares++; $display("FAIL mid_rst_ready: got %b expected 0000", in_ready); end
        to_drive();
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'hF;
        to_sample();
        vectors++;
        if (out_valid !== 1'b0 || out_sel !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_rst_out: got %b/%0d expected 0/0", out_valid, out_sel);
        end
        vectors++;
        if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL mid_rst_first: got %b expected 0001", in_ready); end
        to_drive();
        in_valid = 4'b0;
        to_sample();
        vectors++;
        if (out_sel !== 2'd0 || out_data !== 32'hA0) begin
            miscompares++;
            $display("FAIL mid_rst_word: got %0d/%h expected 0/000000a0", out_sel, out_data);
        end
        to_drive();
    endtask

    task automatic test_n3();
        int seq [4] = '{0, 2, 0, 2};
        w3         = '{8'h10, 8'h20, 8'h30};
        in3_valid  = 3'b101;
        out3_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            to_sample();
            vectors++;
            if (in3_ready !== 3'(1 << seq[k])) begin
                miscompares++;
                $display("FAIL n3_in_ready[%0d]: got %b expected %b", k, in3_ready, 3'(1 << seq[k]));
            end
            if (k > 0) begin
                vectors++;
                if (out3_sel !== 2'(seq[k-1]) || out3_data !== w3[seq[k-1]]) begin
                    miscompares++;
                    $display("FAIL n3_out[%0d]: got %0d/%h expected %0d/%h", k, out3_sel, out3_data,
                             seq[k-1], w3[seq[k-1]]);
                end
            end
            to_drive();
        end
        in3_valid = 3'b0;
        to_sample();
        vectors++;
        if (out3_sel !== 2'd2 || out3_data !== 8'h30) begin
            miscompares++;
            $display("FAIL n3_last: got %0d/%h expected 2/30", out3_sel, out3_data);
        end
        to_drive();
    endtask

`ifdef RR_ARB_MUX_LOCK_EN
    task automatic test_lock();
        rst      = 1'b1;
        in_valid = 4'b0;
        to_drive();
        rst       = 1'b0;
        out_ready = 1'b1;
        words     = '{32'hC0, 32'hB0, 32'hA2, 32'hA3};
        in_valid  = 4'b0001;
        in_last   = 4'b0001;
        to_sample();
        vectors++;
        if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL lock_pre: got %b expected 0001", in_ready); end
        to_drive();
        for (int b = 0; b < 3; b++) begin
            in_valid = 4'b0011;
            words[1] = 32'hB0 + 32'(b);
            in_last  = {2'b00, (b == 2), 1'b1};
            to_sample();
            vectors++;
            if (in_ready !== 4'b0010) begin
                miscompares++;
                $display("FAIL lock_ready[%0d]: got %b expected 0010", b, in_ready);
            end
            if (b > 0) begin
                vectors++;
                if (out_sel !== 2'd1 || out_last !== 1'b0) begin
                    miscompares++;
                    $display("FAIL lock_beat[%0d]: got %0d/%b expected 1/0", b - 1, out_sel, out_last);
                end
            end
            to_drive();
        end
        in_valid = 4'b0011;
        in_last  = 4'b0001;
        to_sample();
        vectors++;
        if (out_sel !== 2'd1 || out_last !== 1'b1 || out_data !== 32'hB2) begin
            miscompares++;
            $display("FAIL lock_final: got %0d/%b/%h expected 1/1/000000b2", out_sel, out_last, out_data);
        end
        vectors++;
        if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL lock_resume: got %b expected 0001", in_ready); end
        to_drive();
        in_valid = 4'b0;
        to_sample();
        vectors++;
        if (out_sel !== 2'd0 || out_last !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_after: got %0d/%b expected 0/1", out_sel, out_last);
        end
        to_drive();
    endtask
`endif

    initial begin
        words = '{32'h0, 32'h0, 32'h0, 32'h0};
        w3    = '{8'h0, 8'h0, 8'h0};
        test_reset();
        test_round_robin();
        test_single();
        test_stall();
        test_reset_mid_stall();
        test_n3();
`ifdef RR_ARB_MUX_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-input, WIDTH-bit multiplexer with a round-robin arbiter and a one-entry registered output stage.
- Each input and the output use valid/ready handshakes.
- Generalises the fixed 4:1 5-bit select mux to any channel count and width, with sequential arbitration and backpressure.
- Used to share one downstream consumer (memory port, writeback bus) between several pipeline sources.

Parameters:
- WIDTH, 32, data width per channel in bits (>=1).
- N, 4, number of input channels (>=1).
- SEL_W, $clog2(N) (minimum 1), width of the channel index. Derived; not overridden.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  channel i has a word to offer.
- in_ready  output  N  channel i's word is captured this cycle; combinational, one-hot or zero.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds an undelivered word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_sel  output  SEL_W  index of the channel that supplied out_data, registered with it.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=N-1, so channel 0 wins first.
  - in_ready=0 while rst=1.
- Load enable: load = !out_valid | out_ready.
- Arbitration is combinational when load=1:
  - Scan channels ptr+1, ptr+2, ... modulo N; the winner is the first with in_valid=1.
  - in_ready[winner]=1; all other in_ready bits are 0.
- When load=0, all in_ready bits are 0. No new grant is issued while the output is stalled.
- On a clk edge with load=1 and a winner:
  - out_data <= winner's word, out_sel <= winner, out_valid <= 1, ptr <= winner.
- On a clk edge with load=1 and no in_valid: out_valid <= 0. out_data and out_sel hold their old values.
- Latency: one cycle from input handshake to out_valid.
- Throughput: one word per cycle when out_ready is held high.
- While out_valid=1 and out_ready=0, out_data and out_sel are stable.
- Simultaneous drain and capture (out_valid=1, out_ready=1, a winner present): the new word replaces the old one in the same edge, with no bubble.
- Fairness: a continuously requesting channel is granted within N grants.
- Pointer wrap: after a grant to N-1, the search starts at 0.
- N=1: ptr is constant 0, and the block degenerates to a registered valid/ready stage.
- in_valid may drop without a handshake; the arbiter re-evaluates every cycle. No grant is held across cycles except under the optional lock.
- Reset mid-stall: a pending output word is discarded, out_valid=0, and no handshake is reported.

Optional Feature:
- Macro: RR_ARB_MUX_LOCK_EN.
- When defined:
  - Adds input port in_last (N bits) and output port out_last (1 bit, registered with out_data).
  - After a channel is granted with in_last=0, the arbiter is locked to that channel. in_ready can go only to it until a beat with in_last=1 is captured; then round-robin resumes from that channel.
  - Other channels' in_valid is ignored while locked.
  - Reset clears the lock.
- When undefined:
  - No in_last/out_last ports and no lock state.
  - Every beat is arbitrated independently.

Decomposition:
- Shared package rr_arb_pkg holds the SEL_W computation function (clog2 with minimum 1).
- The same package holds the reset-pointer constant.
- One natural sub-module: rr_arb_pick.
  - Purely combinational.
  - Inputs: request vector and ptr. Outputs: one-hot grant, grant index, any-grant flag.
  - Reusable by other arbiters.
- The top level holds the output register, ptr and lock state.

Test Plan:
- Reset, then in_valid=4'b1111 with distinct words 0xA0..0xA3 and out_ready=1 held → out_sel sequence 0,1,2,3,0 on consecutive cycles; one in_ready per cycle, one-hot.
- in_valid=4'b0100 only, word 0x55 → in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=0x55, out_sel=2.
- Capture 0x11 from channel 1, then hold out_ready=0 for 5 cycles with all inputs valid → out_data=0x11 stable, in_ready=0 throughout. Raise out_ready → 0x11 is accepted and channel 2's word loads on the same edge.
- Assert rst while out_valid=1 and out_ready=0 → next cycle out_valid=0, out_sel=0; with all requesting, the first grant goes to channel 0.
- N=3, WIDTH=8, channels 0 and 2 always valid → grants alternate 0,2,0,2.
- RR_ARB_MUX_LOCK_EN defined, channel 1 sends 3 beats (in_last on beat 3) with channel 0 valid throughout → out_sel=1,1,1 with out_last=0,0,1, then channel 2 or 0 wins per the pointer.
